// File: rtl/t08_mem_pkg.sv
// Shared constants, access-size encodings and responder state type.
package t08_mem_pkg;

  localparam logic [31:0] I2C_ADDRESS  = 32'd923923;
  localparam logic [31:0] RAM_LIMIT    = 32'd2048;
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    SZ_B  = 3'd0,
    SZ_H  = 3'd1,
    SZ_W  = 3'd2,
    SZ_BU = 3'd4,
    SZ_HU = 3'd5
  } size_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAM,
    S_PERIPH,
    S_RESP
  } resp_state_t;

endpackage

// File: rtl/t08_mem_responder_lane_align.sv
// Combinational byte-lane alignment: lane enables, store shift, load shift/mask.
module t08_lane_align
  import t08_mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  sel,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_sh
);

  logic [1:0]  off;
  logic [31:0] mask;

  // Unsupported size codes fall back to a full-word access.
  always_comb begin
    off  = 2'd0;
    sel  = 4'b1111;
    mask = '1;
    case (func3)
      SZ_B, SZ_BU: begin
        off  = lane;
        sel  = 4'b0001 << lane;
        mask = 32'h0000_00FF;
      end
      SZ_H, SZ_HU: begin
        off  = {lane[1], 1'b0};
        sel  = 4'b0011 << {lane[1], 1'b0};
        mask = 32'h0000_FFFF;
      end
      default: ;
    endcase
  end

  assign wdata_sh = wdata << {off, 3'b000};
  assign rdata_sh = (rword >> {off, 3'b000}) & mask;

endmodule

// File: rtl/t08_mem_responder.sv
// Load/store responder: decodes to RAM or the I2C word and sequences the access.
// Optional peripheral timeout enabled by defining T08_RESP_TIMEOUT_EN.
module t08_mem_responder
  import t08_mem_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic [2:0]  func3,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        ram_en,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        i2c_req,
  output logic        i2c_we,
  output logic [31:0] i2c_wdata,
  input  logic [31:0] i2c_rdata,
  input  logic        i2c_ack
);

  resp_state_t state, state_nx;

  logic [10:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  func3_q;
  logic        we_q;
  logic [31:0] wcnt;

  logic        req;
  logic        is_ram;
  logic        is_i2c;
  logic        timed_out;
  logic [3:0]  sel_al;
  logic [31:0] wdata_al;
  logic [31:0] rdata_al;

  assign req    = read | write;
  assign is_ram = address < RAM_LIMIT;
  assign is_i2c = address == I2C_ADDRESS;

`ifdef T08_RESP_TIMEOUT_EN
  logic [31:0] tcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tcnt <= '0;
    else if (state == S_PERIPH) tcnt <= tcnt + 32'd1;
    else                       tcnt <= '0;
  end

  assign timed_out = (state == S_PERIPH) && !i2c_ack && (tcnt == TIMEOUT - 32'd1);
`else
  assign timed_out = 1'b0;
`endif

  t08_lane_align u_align (
    .func3    (func3_q),
    .lane     (addr_q[1:0]),
    .wdata    (wdata_q),
    .rword    (ram_rdata),
    .sel      (sel_al),
    .wdata_sh (wdata_al),
    .rdata_sh (rdata_al)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (is_ram)      state_nx = S_RAM;
          else if (is_i2c) state_nx = S_PERIPH;
          else             state_nx = S_RESP;
        end
      end
      S_RAM:    if (wcnt == '0) state_nx = S_RESP;
      S_PERIPH: if (i2c_ack || timed_out) state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      we_q    <= 1'b0;
      wcnt    <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q  <= address[10:0];
            wdata_q <= wdata;
            func3_q <= func3;
            we_q    <= write;
            wcnt    <= RAM_WAIT;
            if (!write && !is_ram && !is_i2c) rdata <= '0;
          end
        end
        S_RAM: begin
          if (wcnt == '0) begin
            if (!we_q) rdata <= rdata_al;
          end else begin
            wcnt <= wcnt - 32'd1;
          end
        end
        S_PERIPH: begin
          if (i2c_ack && !we_q)        rdata <= i2c_rdata;
          else if (timed_out && !we_q) rdata <= TIMEOUT_FILL;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == S_RAM) || (state == S_PERIPH) || ((state == S_IDLE) && req);
  assign done      = state == S_RESP;
  assign ram_en    = state == S_RAM;
  assign ram_we    = (state == S_RAM) && we_q;
  assign ram_sel   = (state == S_RAM) ? sel_al : '0;
  assign ram_addr  = addr_q[10:2];
  assign ram_wdata = (state == S_RAM) ? wdata_al : '0;
  assign i2c_req   = state == S_PERIPH;
  assign i2c_we    = (state == S_PERIPH) && we_q;
  assign i2c_wdata = (state == S_PERIPH) ? wdata_q : '0;

endmodule

// File: tb/tb_t08_mem_responder.sv
// Directed bench for t08_mem_responder with a small byte-lane RAM model.
module tb_t08_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        read, write;
  logic [31:0] address, wdata;
  logic [2:0]  func3;
  logic [31:0] rdata;
  logic        busy, done;
  logic        ram_en, ram_we;
  logic [3:0]  ram_sel;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        i2c_req, i2c_we;
  logic [31:0] i2c_wdata, i2c_rdata;
  logic        i2c_ack;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [512];
  logic [3:0]  sel_seen;
  logic        we_seen;
  logic [31:0] wd_seen;
  logic        busy_req;
  int          lat;

  always #5 clk = ~clk;

  t08_mem_responder #(.RAM_WAIT(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
    .wdata(wdata), .func3(func3), .rdata(rdata), .busy(busy), .done(done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .i2c_req(i2c_req),
    .i2c_we(i2c_we), .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata),
    .i2c_ack(i2c_ack)
  );

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      for (int i = 0; i < 4; i++)
        if (ram_sel[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  // Issues one strobe at a negedge and counts cycles until done (bounded).
  task automatic run_req(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f);
    write = w; read = r; address = a; wdata = d; func3 = f;
    #1 busy_req = busy;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    lat = 1; sel_seen = '0; we_seen = 1'b0; wd_seen = '0;
    while (!done && lat < 50) begin
      if (ram_en) begin sel_seen = ram_sel; we_seen = ram_we; wd_seen = ram_wdata; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; wdata = '0; func3 = '0;
    i2c_ack = 1'b0; i2c_rdata = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if ({busy, done, ram_en, ram_we, i2c_req, i2c_we} !== 6'b0) begin errors++;
      $display("FAIL reset_ctrl got %b exp 000000", {busy, done, ram_en, ram_we, i2c_req, i2c_we}); end
    checks++; if (ram_sel !== 4'h0) begin errors++; $display("FAIL reset_sel got %b exp 0000", ram_sel); end
    checks++; if ({ram_wdata, i2c_wdata} !== 64'h0) begin errors++;
      $display("FAIL reset_wdata got %h %h exp 0", ram_wdata, i2c_wdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sw_lw();
    run_req(1'b1, 1'b0, 32'h10, 32'h1234_5678, 3'd2);
    checks++; if (busy_req !== 1'b1) begin errors++; $display("FAIL sw_busy_req got %b exp 1", busy_req); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL sw_latency got %0d exp 4", lat); end
    checks++; if (sel_seen !== 4'b1111 || we_seen !== 1'b1) begin errors++;
      $display("FAIL sw_sel_we got %b/%b exp 1111/1", sel_seen, we_seen); end
    checks++; if (mem[4] !== 32'h1234_5678) begin errors++; $display("FAIL sw_mem got %h exp 12345678", mem[4]); end
    @(negedge clk);
    run_req(1'b0, 1'b1, 32'h10, 32'h0, 3'd2);
    checks++; if (lat !== 4) begin errors++; $display("FAIL lw_latency got %0d exp 4", lat); end
    checks++; if (sel_seen !== 4'b1111 || we_seen !== 1'b0) begin errors++;
      $display("FAIL lw_sel_we got %b/%b exp 1111/0", sel_seen, we_seen); end
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL lw_rdata got %h exp 12345678", rdata); end
    @(negedge clk);
  endtask

  task automatic test_sb_lbu();
    run_req(1'b1, 1'b0, 32'h13, 32'h0000_00AB, 3'd0);
    checks++; if (sel_seen !== 4'b1000) begin errors++; $display("FAIL sb_sel got %b exp 1000", sel_seen); end
    checks++; if (wd_seen[31:24] !== 8'hAB) begin errors++; $display("FAIL sb_wdata got %h exp AB", wd_seen[31:24]); end
    checks++; if (mem[4] !== 32'hAB34_5678) begin errors++; $display("FAIL sb_mem got %h exp AB345678", mem[4]); end
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL sb_rdata_hold got %h exp 12345678", rdata); end
    @(negedge clk);
    run_req(1'b0, 1'b1, 32'h13, 32'h0, 3'd4);
    checks++; if (rdata !== 32'h0000_00AB) begin errors++; $display("FAIL lbu_rdata got %h exp 000000AB", rdata); end
    @(negedge clk);
    run_req(1'b0, 1'b1, 32'h13, 32'h0, 3'd5);
    checks++; if (sel_seen !== 4'b1100) begin errors++; $display("FAIL lhu_sel got %b exp 1100", sel_seen); end
    checks++; if (rdata !== 32'h0000_AB34) begin errors++; $display("FAIL lhu_rdata got %h exp 0000AB34", rdata); end
    @(negedge clk);
    run_req(1'b0, 1'b1, 32'h11, 32'h0, 3'd0);
    checks++; if (rdata !== 32'h0000_0056) begin errors++; $display("FAIL lb1_rdata got %h exp 00000056", rdata); end
    @(negedge clk);
  endtask

  task automatic test_periph_read();
    read = 1'b1; address = 32'd923923; func3 = 3'd0;
    #1 busy_req = busy;
    @(negedge clk);
    read = 1'b0;
    checks++; if (busy_req !== 1'b1) begin errors++; $display("FAIL pr_busy_req got %b exp 1", busy_req); end
    for (int i = 1; i <= 6; i++) begin
      checks++; if (i2c_req !== 1'b1 || busy !== 1'b1 || i2c_we !== 1'b0) begin errors++;
        $display("FAIL pr_hold cyc %0d got req=%b busy=%b we=%b exp 1 1 0", i, i2c_req, busy, i2c_we); end
      if (i == 6) begin i2c_ack = 1'b1; i2c_rdata = 32'hCAFE_0001; end
      @(negedge clk);
    end
    i2c_ack = 1'b0; i2c_rdata = '0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || i2c_req !== 1'b0) begin errors++;
      $display("FAIL pr_done got done=%b busy=%b req=%b exp 1 0 0", done, busy, i2c_req); end
    checks++; if (rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL pr_rdata got %h exp CAFE0001", rdata); end
    @(negedge clk);
    i2c_ack = 1'b1;
    @(negedge clk);
    i2c_ack = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL idle_ack got done=%b busy=%b exp 0 0", done, busy); end
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    run_req(1'b1, 1'b0, 32'h4000, 32'hFFFF_FFFF, 3'd2);
    checks++; if (lat !== 1 || sel_seen !== 4'h0) begin errors++;
      $display("FAIL unw_lat got %0d sel %b exp 1 0000", lat, sel_seen); end
    checks++; if (rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL unw_rdata got %h exp CAFE0001", rdata); end
    @(negedge clk);
    run_req(1'b0, 1'b1, 32'h4000, 32'h0, 3'd2);
    checks++; if (lat !== 1) begin errors++; $display("FAIL unr_lat got %0d exp 1", lat); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unr_rdata got %h exp 0", rdata); end
    @(negedge clk);
  endtask

  task automatic test_both_strobes();
    run_req(1'b1, 1'b1, 32'h20, 32'h55AA_55AA, 3'd2);
    checks++; if (we_seen !== 1'b1 || lat !== 4) begin errors++;
      $display("FAIL both_we got we=%b lat=%0d exp 1 4", we_seen, lat); end
    checks++; if (mem[8] !== 32'h55AA_55AA) begin errors++; $display("FAIL both_mem got %h exp 55AA55AA", mem[8]); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int first, second, cnt;
    first = 0; second = 0; cnt = 0;
    read = 1'b1; address = 32'h10; func3 = 3'd2;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (cnt == 1) first = c; else if (cnt == 2) second = c;
      end
      if (c == 5) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_idle_busy got %b exp 1", busy); end
      end
      if (c == 9) read = 1'b0;
    end
    checks++; if (cnt !== 2 || first !== 4 || second !== 9) begin errors++;
      $display("FAIL b2b_done got cnt=%0d at %0d,%0d exp 2 at 4,9", cnt, first, second); end
  endtask

  task automatic test_reset_mid_periph();
    read = 1'b1; address = 32'd923923; func3 = 3'd2;
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
    checks++; if (i2c_req !== 1'b1) begin errors++; $display("FAIL rmp_pre_req got %b exp 1", i2c_req); end
    rst = 1'b1;
    #1;
    checks++; if (i2c_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL rmp_async got req=%b busy=%b done=%b exp 0 0 0", i2c_req, busy, done); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin errors++;
      $display("FAIL rmp_idle got done=%b busy=%b rdata=%h exp 0 0 0", done, busy, rdata); end
  endtask

`ifdef T08_RESP_TIMEOUT_EN
  task automatic test_timeout();
    int hi;
    hi = 0;
    read = 1'b1; address = 32'd923923; func3 = 3'd2;
    @(negedge clk);
    read = 1'b0;
    while (i2c_req && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    checks++; if (hi !== 8) begin errors++; $display("FAIL to_req_cycles got %0d exp 8", hi); end
    checks++; if (done !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL to_done got done=%b rdata=%h exp 1 DEADBEEF", done, rdata); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_sw_lw();
    test_sb_lbu();
    test_periph_read();
    test_unmapped();
    test_both_strobes();
    test_back_to_back();
    @(negedge clk);
    test_reset_mid_periph();
`ifdef T08_RESP_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
